hilo_ctrl: RTL

//  Downstream consumer of the Booth multiplier and the divider; sits between them and the main control unit.
//  - Launches one mult or div per request.
//  - Waits for the unit's stop strobe.
//  - Commits the 64-bit result into the architectural HI/LO registers.
//  - Holds w_Busy so the control unit stalls mfhi/mflo and any new mult/div.
//  - Flags divide-by-zero and a hung unit via a watchdog counter.

---
 rtl/hilo_pkg.sv | 15 +
 rtl/hilo_wdog.sv | 36 +++
 rtl/hilo_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/hilo_pkg.sv
// Shared types and default parameters for the HI/LO result controller.
package hilo_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int TIMEOUT_DEF = 48;
    // Narrowest counter that can hold TIMEOUT_DEF.
    localparam int CNT_W_DEF   = $clog2(TIMEOUT_DEF + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_MULT = 2'd1,
        WAIT_DIV  = 2'd2
    } state_t;

endpackage

// File: rtl/hilo_wdog.sv
// Watchdog for hilo_ctrl: counts wait cycles and flags the cycle in which
// the count reaches TIMEOUT.
module hilo_wdog
    import hilo_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic Clock,
    input  logic Reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count_r;

    // Wait-cycle counter, held at zero while cleared.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            count_r <= {CNT_W{1'b0}};
        end else if (enable) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    // The current wait cycle is the TIMEOUT-th one when count_r sits one below.
    assign expired = enable && (count_r == LAST_CNT);

endmodule

// File: rtl/hilo_ctrl.sv
// HI/LO controller: launches mult/div, commits results, flags div-by-zero and
// hung units. Optional HILO_MT_EN adds direct HI/LO writes (mthi/mtlo).
module hilo_ctrl
    import hilo_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              w_MultOp,
    input  logic              w_DivOp,
    output logic              w_MultStart,
    output logic              w_DivStart,
    input  logic              w_MultStop,
    input  logic [DATA_W-1:0] w_MULTHI,
    input  logic [DATA_W-1:0] w_MULTLO,
    input  logic              w_DivStop,
    input  logic [DATA_W-1:0] w_DIVHI,
    input  logic [DATA_W-1:0] w_DIVLO,
    input  logic              w_DivZero,
    output logic [DATA_W-1:0] w_HI,
    output logic [DATA_W-1:0] w_LO,
    output logic              w_Busy,
    output logic              w_Done,
    output logic              w_DivZeroExc,
    output logic              w_Timeout
`ifdef HILO_MT_EN
    ,
    input  logic              w_MTHI,
    input  logic              w_MTLO,
    input  logic [DATA_W-1:0] w_MTData
`endif
);

    state_t            state_r, state_s;
    logic              mult_start_r, mult_start_s;
    logic              div_start_r, div_start_s;
    logic              done_r, done_s;
    logic              dze_r, dze_s;
    logic              timeout_r, timeout_s;
    logic [DATA_W-1:0] hi_r, hi_s;
    logic [DATA_W-1:0] lo_r, lo_s;
    logic              wdog_expired_s;

    hilo_wdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_wdog (
        .Clock   (Clock),
        .Reset   (Reset),
        .clear   (state_r == IDLE),
        .enable  (state_r != IDLE),
        .expired (wdog_expired_s)
    );

    // State register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; stops are only honoured from the unit that was launched.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (w_MultOp) begin
                    state_s = WAIT_MULT;
                end else if (w_DivOp) begin
                    state_s = WAIT_DIV;
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT_MULT: begin
                if (w_MultStop || wdog_expired_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = WAIT_MULT;
                end
            end
            WAIT_DIV: begin
                if (w_DivStop || wdog_expired_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = WAIT_DIV;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Output next-values; a stop in the expiry cycle still commits.
    always_comb begin
        mult_start_s = 1'b0;
        div_start_s  = 1'b0;
        done_s       = 1'b0;
        dze_s        = 1'b0;
        timeout_s    = timeout_r;
        hi_s         = hi_r;
        lo_s         = lo_r;
        case (state_r)
            IDLE: begin
                if (w_MultOp) begin
                    mult_start_s = 1'b1;
                end else if (w_DivOp) begin
                    div_start_s = 1'b1;
                end else begin
`ifdef HILO_MT_EN
                    hi_s = w_MTHI ? w_MTData : hi_r;
                    lo_s = w_MTLO ? w_MTData : lo_r;
`else
                    hi_s = hi_r;
                    lo_s = lo_r;
`endif
                end
            end
            WAIT_MULT: begin
                if (w_MultStop) begin
                    hi_s   = w_MULTHI;
                    lo_s   = w_MULTLO;
                    done_s = 1'b1;
                end else if (wdog_expired_s) begin
                    timeout_s = 1'b1;
                end else begin
                    timeout_s = timeout_r;
                end
            end
            WAIT_DIV: begin
                if (w_DivStop) begin
                    if (w_DivZero) begin
                        dze_s = 1'b1;
                    end else begin
                        hi_s   = w_DIVHI;
                        lo_s   = w_DIVLO;
                        done_s = 1'b1;
                    end
                end else if (wdog_expired_s) begin
                    timeout_s = 1'b1;
                end else begin
                    timeout_s = timeout_r;
                end
            end
            default: begin
                timeout_s = timeout_r;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            mult_start_r <= 1'b0;
            div_start_r  <= 1'b0;
            done_r       <= 1'b0;
            dze_r        <= 1'b0;
            timeout_r    <= 1'b0;
            hi_r         <= {DATA_W{1'b0}};
            lo_r         <= {DATA_W{1'b0}};
        end else begin
            mult_start_r <= mult_start_s;
            div_start_r  <= div_start_s;
            done_r       <= done_s;
            dze_r        <= dze_s;
            timeout_r    <= timeout_s;
            hi_r         <= hi_s;
            lo_r         <= lo_s;
        end
    end

    assign w_MultStart  = mult_start_r;
    assign w_DivStart   = div_start_r;
    assign w_Done       = done_r;
    assign w_DivZeroExc = dze_r;
    assign w_Timeout    = timeout_r;
    assign w_HI         = hi_r;
    assign w_LO         = lo_r;
    assign w_Busy       = (state_r != IDLE);

endmodule
